// File: rtl/tuart_pkg.sv
// Shared UART definitions for the host-link transmitter and receiver.
// Frame levels and the serializer state set live here so both directions agree.
package tuart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tuart_tx_word.sv
// Serializes one word as start bit, WORD_BITS data bits (LSB first), stop bit.
// A strobe in the last stop cycle chains the next frame with no idle gap.
module tuart_tx_word
    import tuart_pkg::*;
#(
    parameter int WORD_BITS   = 8,
    parameter int CLK_PER_BIT = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 word_stb_i,
    input  logic [WORD_BITS-1:0] word_data_i,
    output logic                 word_done_o,
    output logic                 word_busy_o,
    output logic                 tx_o
);

    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W  = $clog2(WORD_BITS + 1);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 baud_last;
    logic                 bit_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        baud_last   = (baud_q == BAUD_W'(CLK_PER_BIT - 1));
        bit_last    = (bit_q == BIT_W'(WORD_BITS - 1));
        word_done_o = (state_q == STOP) && baud_last;
        word_busy_o = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (word_stb_i) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = word_data_i;
                    tx_d    = START_BIT;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_last) begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chained word: go straight to its start bit from the last stop cycle.
                    if (word_stb_i) begin
                        state_d = START;
                        shift_d = word_data_i;
                        tx_d    = START_BIT;
                    end else begin
                        state_d = IDLE;
                        tx_d    = IDLE_LEVEL;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/tuart_tx.sv
// Host-link UART transmitter: latches a multi-word sample plus enable mask and
// streams each enabled word, lowest index first, as back-to-back 8N1 frames.
module tuart_tx
    import tuart_pkg::*;
#(
    parameter int WORD_BITS   = 8,
    parameter int XFER_WORDS  = 4,
    parameter int CLK_PER_BIT = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [WORD_BITS*XFER_WORDS-1:0] data_i,
    input  logic [XFER_WORDS-1:0]           en_i,
    input  logic                            stb_i,
    output logic                            rdy_o,
    output logic                            tx_o
);

    localparam int                IDX_W   = $clog2(XFER_WORDS + 1);
    localparam logic [IDX_W-1:0]  NO_WORD = IDX_W'(XFER_WORDS);

    if (CLK_PER_BIT < 2) begin : g_cpb_check
        $error("tuart_tx: CLK_PER_BIT must be 2 or more");
    end

    logic                            busy_q;
    logic [XFER_WORDS-1:0]           pend_q;
    logic [WORD_BITS*XFER_WORDS-1:0] data_q;
    logic [XFER_WORDS-1:0]           src_mask, rem_mask;
    logic [WORD_BITS*XFER_WORDS-1:0] src_data;
    logic [IDX_W-1:0]                nxt_idx;
    logic [WORD_BITS-1:0]            word_data;
    logic                            have_word, accept, word_stb, word_done, word_busy;

    // While idle the selection looks at the live inputs so the first start bit
    // leaves on the accepting edge; afterwards it works from the latched copy.
    always_comb begin
        accept    = stb_i && !busy_q;
        src_mask  = busy_q ? pend_q : en_i;
        src_data  = busy_q ? data_q : data_i;
        nxt_idx   = NO_WORD;
        word_data = '0;
        rem_mask  = src_mask;
        for (int n = XFER_WORDS - 1; n >= 0; n--) begin
            if (src_mask[n]) begin
                nxt_idx   = IDX_W'(n);
                word_data = src_data[n*WORD_BITS +: WORD_BITS];
            end
        end
        for (int n = 0; n < XFER_WORDS; n++) begin
            if (nxt_idx == IDX_W'(n)) rem_mask[n] = 1'b0;
        end
        have_word = (nxt_idx != NO_WORD);
        word_stb  = have_word && (accept || (busy_q && word_done));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            pend_q <= '0;
        end else if (accept) begin
            busy_q <= 1'b1;
            pend_q <= rem_mask;
        end else if (busy_q) begin
            if (word_stb) begin
                pend_q <= rem_mask;
            end else if (!word_busy || word_done) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) data_q <= data_i;
    end

    tuart_tx_word #(
        .WORD_BITS   (WORD_BITS),
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_word (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .word_stb_i  (word_stb),
        .word_data_i (word_data),
        .word_done_o (word_done),
        .word_busy_o (word_busy),
        .tx_o        (tx_o)
    );

    assign rdy_o = !busy_q;

endmodule

// File: tb/tb_tuart_tx.sv
// Self-checking bench for tuart_tx: vector table, hand-written corner sequences
// and randomized transfers compared against a waveform-level reference model.
module tb_tuart_tx;

    localparam int WB    = 8;
    localparam int XW    = 4;
    localparam int CPB   = 5;
    localparam int FRAME = (WB + 2) * CPB;
    localparam int TRN   = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [3:0]  en;
    logic        stb;
    logic        rdy;
    logic        tx;

    int checks = 0;
    int errors = 0;

    logic tx_tr  [TRN];
    logic rdy_tr [TRN];
    bit   exp_line[$];
    logic [7:0] dq[$];
    int   sq[$];
    int   ferr;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  en;
        logic [63:0] bytes;
        int          nbytes;
        int          busy;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    tuart_tx #(
        .WORD_BITS   (WB),
        .XFER_WORDS  (XW),
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data),
        .en_i   (en),
        .stb_i  (stb),
        .rdy_o  (rdy),
        .tx_o   (tx)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: the ideal line waveform, one entry per clock, for one transfer.
    task automatic model_add(input logic [31:0] d, input logic [3:0] e);
        for (int w = 0; w < XW; w++) begin
            if (e[w]) begin
                for (int c = 0; c < CPB; c++) exp_line.push_back(1'b0);
                for (int b = 0; b < WB; b++)
                    for (int c = 0; c < CPB; c++) exp_line.push_back(d[w*WB + b]);
                for (int c = 0; c < CPB; c++) exp_line.push_back(1'b1);
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] e);
        data = d;
        en   = e;
        stb  = 1'b1;
        step();
        stb  = 1'b0;
    endtask

    // mode 0: quiet; 1: random strobes while busy (cycles <= arg);
    // 2: one all-ones strobe at cycle arg; 3: strobe held until cycle arg.
    task automatic capture(input int n, input int mode, input int arg);
        for (int i = 1; i <= n; i++) begin
            tx_tr[i]  = tx;
            rdy_tr[i] = rdy;
            case (mode)
                1: begin
                    if (i <= arg) begin
                        stb  = 1'($urandom_range(0, 1));
                        data = $urandom;
                        en   = 4'($urandom_range(0, 15));
                    end else begin
                        stb = 1'b0;
                    end
                end
                2: begin
                    if (i == arg) begin
                        stb  = 1'b1;
                        data = 32'hFFFF_FFFF;
                        en   = 4'hF;
                    end else begin
                        stb = 1'b0;
                    end
                end
                3: stb = (i < arg);
                default: stb = 1'b0;
            endcase
            step();
        end
    endtask

    task automatic check_line(input string name, input int n);
        int  mism;
        logic expb;
        mism = 0;
        for (int i = 1; i <= n; i++) begin
            expb = (i <= exp_line.size()) ? exp_line[i-1] : 1'b1;
            if (tx_tr[i] !== expb) mism++;
        end
        check({name, " line_mismatch_cycles"}, mism, 0);
    endtask

    task automatic check_rdy(input string name, input int n, input int busy);
        int first;
        first = 0;
        for (int i = 1; i <= n; i++)
            if (rdy_tr[i] === 1'b1 && first == 0) first = i;
        check({name, " rdy_return_cycle"}, first, busy + 1);
    endtask

    task automatic decode(input int n);
        int         i;
        logic       prev;
        logic [7:0] b;
        dq.delete();
        sq.delete();
        ferr = 0;
        i = 1;
        while (i <= n) begin
            prev = (i == 1) ? 1'b1 : tx_tr[i-1];
            if (prev === 1'b1 && tx_tr[i] === 1'b0 && i + FRAME - 1 <= n) begin
                for (int bi = 0; bi < WB; bi++) b[bi] = tx_tr[i + CPB*(1+bi) + CPB/2];
                if (tx_tr[i + CPB*(WB+1) + CPB/2] !== 1'b1) ferr++;
                dq.push_back(b);
                sq.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    function automatic logic [63:0] packed_bytes();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < dq.size() && k < 8; k++) v[k*8 +: 8] = dq[k];
        return v;
    endfunction

    task automatic check_starts(input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < sq.size(); k++)
            if (sq[k] != 1 + FRAME*k) bad++;
        check({name, " frame_spacing_errors"}, bad, 0);
    endtask

    initial begin
        int busy_m;
        int first;
        string nm;

        tbl[0] = '{32'h1122_3344, 4'b1111, 64'h1122_3344, 4, 200};
        tbl[1] = '{32'hAABB_CCDD, 4'b0101, 64'h0000_BBDD, 2, 100};
        tbl[2] = '{32'hDEAD_BEEF, 4'b0000, 64'h0,         0, 1};
        tbl[3] = '{32'h1234_5678, 4'b1000, 64'h0000_0012, 1, 50};
        tbl[4] = '{32'h00FF_00FF, 4'b0110, 64'h0000_FF00, 2, 100};
        tbl[5] = '{32'h8000_0001, 4'b1001, 64'h0000_8001, 2, 100};

        rst  = 1'b1;
        stb  = 1'b0;
        data = '0;
        en   = '0;
        @(negedge clk);
        step();
        step();
        check("reset tx", tx, 1);
        check("reset rdy", rdy, 1);
        rst = 1'b0;
        step();
        check("post_reset tx", tx, 1);
        check("post_reset rdy", rdy, 1);

        for (int k = 0; k < 6; k++) begin
            nm = $sformatf("vec%0d", k);
            exp_line.delete();
            model_add(tbl[k].data, tbl[k].en);
            send(tbl[k].data, tbl[k].en);
            capture(260, 0, 0);
            check_line(nm, 260);
            check_rdy(nm, 260, tbl[k].busy);
            decode(260);
            check({nm, " byte_count"}, dq.size(), tbl[k].nbytes);
            check({nm, " bytes"}, packed_bytes(), tbl[k].bytes);
            check_starts(nm);
            check({nm, " stop_bit_errors"}, ferr, 0);
        end

        // Strobe with all-ones payload while the first transfer is on the line.
        exp_line.delete();
        model_add(32'h1122_3344, 4'b1111);
        send(32'h1122_3344, 4'b1111);
        capture(260, 2, 30);
        check_line("busy_stb", 260);
        check_rdy("busy_stb", 260, 200);
        decode(260);
        check("busy_stb bytes", packed_bytes(), 64'h1122_3344);
        check("busy_stb byte_count", dq.size(), 4);

        // Strobe held high across two transfers.
        exp_line.delete();
        model_add(32'h0102_0304, 4'hF);
        exp_line.push_back(1'b1);
        model_add(32'h0506_0708, 4'hF);
        data = 32'h0102_0304;
        en   = 4'hF;
        stb  = 1'b1;
        step();
        data = 32'h0506_0708;
        capture(410, 3, 202);
        check_line("b2b", 410);
        decode(410);
        check("b2b byte_count", dq.size(), 8);
        check("b2b bytes", packed_bytes(), 64'h0506_0708_0102_0304);
        if (sq.size() == 8) check("b2b idle_gap", sq[4] - (sq[3] + FRAME), 1);
        else                check("b2b idle_gap frames", sq.size(), 8);
        check("b2b rdy_between", rdy_tr[201], 1);
        first = 0;
        for (int i = 202; i <= 410; i++)
            if (rdy_tr[i] === 1'b1 && first == 0) first = i;
        check("b2b rdy_second_return", first, 402);

        // Reset during the first frame's data bits.
        send(32'h5A5A_5A5A, 4'hF);
        capture(22, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid tx", tx, 1);
        check("rst_mid rdy", rdy, 1);
        exp_line.delete();
        capture(60, 0, 0);
        check_line("rst_mid no_resume", 60);
        model_add(32'h0000_00A5, 4'b0001);
        send(32'h0000_00A5, 4'b0001);
        capture(80, 0, 0);
        check_line("rst_mid after", 80);
        check_rdy("rst_mid after", 80, 50);
        decode(80);
        check("rst_mid after byte_count", dq.size(), 1);
        check("rst_mid after bytes", packed_bytes(), 64'hA5);

        // Randomized transfers with random strobe noise while busy.
        for (int r = 0; r < 20; r++) begin
            logic [31:0] d;
            logic [3:0]  e;
            d = $urandom;
            e = 4'($urandom_range(0, 15));
            exp_line.delete();
            model_add(d, e);
            busy_m = (exp_line.size() == 0) ? 1 : exp_line.size();
            nm = $sformatf("rand%0d", r);
            send(d, e);
            capture(210, 1, busy_m);
            check_line(nm, 210);
            check_rdy(nm, 210, busy_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tuart_tx.md
Name: tuart_tx

Overview:
- UART transmitter for the host link of the logic analyzer; counterpart of the command receiver.
- Accepts one sample of XFER_WORDS words in parallel, plus a per-word enable mask, in a single strobe.
- Serializes each enabled word as an 8N1-style frame, LSB word first and LSB bit first, on tx_o.
- Used by the readout path to stream captured samples, with disabled channel groups skipped, back to the host.

Parameters:
- WORD_BITS, 8, data bits per UART frame.
- XFER_WORDS, 4, words per accepted transfer.
- CLK_PER_BIT, 5, clk_i cycles per serial bit. Legal range is 2 or more; elaboration fails below 2.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- data_i  in  WORD_BITS*XFER_WORDS  transfer payload; word n = data_i[n*WORD_BITS +: WORD_BITS].
- en_i  in  XFER_WORDS  word enable mask; bit n set means word n is transmitted.
- stb_i  in  1  transfer request; qualified by rdy_o.
- rdy_o  out  1  block idle and able to accept a transfer.
- tx_o  out  1  serial line; idle high.

Behaviour:
- Reset values: tx_o=1, rdy_o=1, all state in IDLE, counters 0. Reset mid-frame aborts immediately; tx_o is 1 the next cycle and no partial frame resumes.
- Handshake:
  - A transfer is accepted on the clock edge where stb_i=1 and rdy_o=1. data_i and en_i are latched at that edge; later changes have no effect.
  - rdy_o=0 from the cycle after acceptance until the transfer completes.
  - stb_i while rdy_o=0 is ignored: no queueing and no error.
- States:
  - IDLE -> START on acceptance, selecting the lowest-index enabled word.
  - START (tx_o=0, CLK_PER_BIT cycles) -> DATA.
  - DATA (WORD_BITS bits, LSB first, each held CLK_PER_BIT cycles) -> STOP.
  - STOP (tx_o=1, CLK_PER_BIT cycles) -> START of the next higher-index enabled word if one remains, else IDLE.
  - IDLE drives rdy_o=1.
- Latency: tx_o falls in the first cycle after the accepting edge.
- Frame length: 10*CLK_PER_BIT cycles for WORD_BITS=8 (in general (WORD_BITS+2)*CLK_PER_BIT). Consecutive frames are back-to-back with no extra idle bit.
- Disabled words produce no frame and consume no line time.
- en_i all zero: transfer is accepted, tx_o stays 1, and rdy_o is 0 for exactly one cycle.
- Completion: rdy_o=1 in the cycle after the last STOP cycle. A new stb_i in that cycle is accepted, so full-rate streaming leaves exactly one idle-high cycle between transfers.
- Counters:
  - Bit-time counter runs 0..CLK_PER_BIT-1 and wraps, sized $clog2(CLK_PER_BIT).
  - Bit index counter is sized $clog2(WORD_BITS+1).
  - Word index counter is sized $clog2(XFER_WORDS+1).
  - No counter may overflow at parameter maxima.
- tx_o is driven from a register (no combinational glitches on the line).

Decomposition:
- tuart_pkg holds the shared UART definitions:
  - the tx state enum (IDLE, START, DATA, STOP), also usable by the receiver side;
  - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- One sub-module, tuart_tx_word, serializes a single word: start, data, stop, with a baud counter, a word_stb_i input and a word_done_o output.
- The top level holds the transfer latch, the mask, next-enabled-word selection and the rdy_o handshake.

Test Plan (WORD_BITS=8, XFER_WORDS=4, CLK_PER_BIT=5):
- Full transfer: data_i=0x11223344, en_i=4'b1111, stb_i for 1 cycle.
  - Required: bytes 0x44, 0x33, 0x22, 0x11 decoded from tx_o; each frame 50 cycles; 200 busy cycles.
  - Required: rdy_o=1 at accept+201.
- Masked transfer: data_i=0xAABBCCDD, en_i=4'b0101.
  - Required: only 0xDD then 0xBB on the line; 100 line cycles; rdy_o returns at accept+101.
- Empty mask: en_i=4'b0000.
  - Required: tx_o constant 1; rdy_o low exactly one cycle.
- Busy strobe: second stb_i with data_i=0xFFFFFFFF issued 30 cycles into the first transfer.
  - Required: ignored; only the first transfer's bytes appear; latched data is unaffected by data_i changes.
- Back-to-back: stb_i held high continuously, two transfers (0x01020304 then 0x05060708).
  - Required: exactly one idle-high cycle between frame 0x01 and frame 0x08; 8 correct bytes in order.
- Reset mid-frame: assert rst_i 1 cycle at cycle 23 of the first frame.
  - Required: tx_o=1 and rdy_o=1 the cycle after reset; a subsequent transfer of 0x000000A5 with en_i=4'b0001 yields a single 0xA5 frame.
